// File: rtl/framebuffer_arbiter_pkg.sv
// Shared SRAM bus types and framebuffer geometry for the display, renderer and clear paths.
package framebuffer_arbiter_pkg;

    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OFFSET_W    = 19;

    localparam int unsigned FB_PIXELS   = 307200;
    localparam int unsigned FB0_BASE    = 0;
    localparam int unsigned FB1_BASE    = 307200;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef logic [ADDR_W-1:0] SramAddress_t;

    typedef struct packed {
        SramAddress_t      address;
        logic [DATA_W-1:0] data;
        logic              oe_n;
        logic              we_n;
        logic              den;
    } SramRequest_t;

    typedef struct packed {
        logic [DATA_W-1:0] din;
        logic              done;
    } SramResult_t;

    typedef logic FbSel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ClearState_t;

    localparam SramRequest_t SRAM_IDLE = '{
        address: '0,
        data:    '0,
        oe_n:    1'b1,
        we_n:    1'b1,
        den:     1'b0
    };

endpackage

// File: rtl/framebuffer_arbiter_clear.sv
// Back-buffer fill engine: walks every pixel offset once, advancing only on cycles the display leaves free.
module fb_clear_engine
    import framebuffer_arbiter_pkg::*;
#(
    parameter int unsigned FB_PIXELS = framebuffer_arbiter_pkg::FB_PIXELS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   color,
    input  logic                slotFree,
    output logic                busy,
    output logic [DATA_W-1:0]   fillColor,
    output logic [OFFSET_W-1:0] cnt
);

    localparam logic [OFFSET_W-1:0] LAST_IDX = OFFSET_W'(FB_PIXELS - 1);

    ClearState_t         state;
    ClearState_t         stateNext;
    logic [OFFSET_W-1:0] cntNext;
    logic [DATA_W-1:0]   colorNext;

    // State, counter and latched fill value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fillColor <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            fillColor <= colorNext;
        end
    end

    // Next state; a start request while clearing is ignored
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        colorNext = fillColor;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                    colorNext = color;
                end
            end
            CLEAR: begin
                if (slotFree) begin
                    if (cnt == LAST_IDX) begin
                        stateNext = IDLE;
                    end else begin
                        cntNext = cnt + OFFSET_W'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the SRAM port between display reads, back-buffer clears and renderer writes; owns double-buffer swapping.
module framebuffer_arbiter
    import framebuffer_arbiter_pkg::*;
#(
    parameter int unsigned FB0_BASE    = framebuffer_arbiter_pkg::FB0_BASE,
    parameter int unsigned FB1_BASE    = framebuffer_arbiter_pkg::FB1_BASE,
    parameter int unsigned FB_PIXELS   = framebuffer_arbiter_pkg::FB_PIXELS,
    parameter int unsigned FRAME_CNT_W = framebuffer_arbiter_pkg::FRAME_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  SramRequest_t           disp_req,
    output SramResult_t            disp_result,
    output SramAddress_t           disp_base,
    input  logic                   paint_done,
    input  logic                   wr_valid,
    input  logic [OFFSET_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   clr_start,
    input  logic [DATA_W-1:0]      clr_color,
    output logic                   clr_busy,
    input  logic                   swap_req,
    output logic                   swap_pending,
    output FbSel_t                 front_sel,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output SramRequest_t           sram_req,
    input  SramResult_t            sram_result
);

    localparam SramAddress_t        FB0_ADDR  = ADDR_W'(FB0_BASE);
    localparam SramAddress_t        FB1_ADDR  = ADDR_W'(FB1_BASE);
    localparam logic [OFFSET_W-1:0] PIX_LIMIT = OFFSET_W'(FB_PIXELS);

    logic                paintDoneQ;
    logic                vblankEdge;
    logic                doSwap;
    logic                dispIdle;
    SramAddress_t        backBase;
    logic [DATA_W-1:0]   fillColor;
    logic [OFFSET_W-1:0] clrCnt;

    assign dispIdle   = disp_req.oe_n;
    assign backBase   = front_sel ? FB0_ADDR : FB1_ADDR;
    assign vblankEdge = paint_done && !paintDoneQ;
    // A clear in flight holds the swap off so the fill never lands in the visible buffer
    assign doSwap     = vblankEdge && (swap_pending || swap_req) && !clr_busy;

    fb_clear_engine #(
        .FB_PIXELS (FB_PIXELS)
    ) u_clear (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (clr_start),
        .color     (clr_color),
        .slotFree  (dispIdle),
        .busy      (clr_busy),
        .fillColor (fillColor),
        .cnt       (clrCnt)
    );

    // Vblank edge detect, frame counter and front/back swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paintDoneQ   <= 1'b0;
            front_sel    <= 1'b0;
            disp_base    <= FB0_ADDR;
            swap_pending <= 1'b0;
            frame_count  <= '0;
        end else begin
            paintDoneQ <= paint_done;
            if (vblankEdge) begin
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
            if (doSwap) begin
                front_sel    <= ~front_sel;
                disp_base    <= front_sel ? FB0_ADDR : FB1_ADDR;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign wr_ready = rst_n && !clr_busy && dispIdle;

    // Fixed-priority port mux: display, then clear, then renderer
    always_comb begin
        sram_req    = SRAM_IDLE;
        disp_result = '0;
        if (rst_n) begin
            if (!dispIdle) begin
                sram_req    = disp_req;
                disp_result = sram_result;
            end else if (clr_busy) begin
                sram_req.address = backBase + SramAddress_t'(clrCnt);
                sram_req.data    = fillColor;
                sram_req.we_n    = 1'b0;
                sram_req.den     = 1'b1;
            end else if (wr_valid && (wr_addr < PIX_LIMIT)) begin
                sram_req.address = backBase + SramAddress_t'(wr_addr);
                sram_req.data    = wr_data;
                sram_req.we_n    = 1'b0;
                sram_req.den     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a reduced 64-pixel buffer and a per-cycle reference model.
module tb_framebuffer_arbiter;
    import framebuffer_arbiter_pkg::*;

    localparam int unsigned PIX = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    SramRequest_t disp_req;
    SramResult_t  disp_result;
    SramAddress_t disp_base;
    logic         paint_done;
    logic         wr_valid;
    logic [18:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         wr_ready;
    logic         clr_start;
    logic [31:0]  clr_color;
    logic         clr_busy;
    logic         swap_req;
    logic         swap_pending;
    logic         front_sel;
    logic [15:0]  frame_count;
    SramRequest_t sram_req;
    SramResult_t  sram_result;

    int compared = 0;
    int mismatched = 0;

    framebuffer_arbiter #(
        .FB_PIXELS (PIX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .disp_req     (disp_req),
        .disp_result  (disp_result),
        .disp_base    (disp_base),
        .paint_done   (paint_done),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .clr_busy     (clr_busy),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .frame_count  (frame_count),
        .sram_req     (sram_req),
        .sram_result  (sram_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic SramRequest_t readReq(input logic [19:0] a);
        SramRequest_t r;
        r = '{address: a, data: '0, oe_n: 1'b0, we_n: 1'b1, den: 1'b0};
        return r;
    endfunction

    // Reference model: which buffer is visible, whether a swap waits, and how far the fill has got
    int          mFront = 0;
    bit          mPending = 0;
    bit          mClearing = 0;
    bit          mPrev = 0;
    int          mIdx = 0;
    logic [31:0] mColor = '0;
    int          mFrames = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mFront = 0; mPending = 0; mClearing = 0; mPrev = 0;
            mIdx = 0; mColor = '0; mFrames = 0;
        end else begin
            bit vb;
            vb = paint_done && !mPrev;
            mPrev = paint_done;
            if (vb) mFrames = (mFrames + 1) % 65536;
            if (vb && (mPending || swap_req) && !mClearing) begin
                mFront = 1 - mFront;
                mPending = 0;
            end else if (swap_req) begin
                mPending = 1;
            end
            if (mClearing) begin
                if (disp_req.oe_n) begin
                    if (mIdx == PIX - 1) mClearing = 0;
                    else mIdx++;
                end
            end else if (clr_start) begin
                mClearing = 1;
                mIdx = 0;
                mColor = clr_color;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        SramRequest_t eReq;
        SramResult_t  eRes;
        int           back;
        back = (mFront == 1) ? 0 : 307200;
        eReq = SRAM_IDLE;
        eRes = '0;
        if (rst_n) begin
            if (!disp_req.oe_n) begin
                eReq = disp_req;
                eRes = sram_result;
            end else if (mClearing) begin
                eReq.address = 20'(back + mIdx);
                eReq.data = mColor;
                eReq.we_n = 1'b0;
                eReq.den = 1'b1;
            end else if (wr_valid && int'(wr_addr) < PIX) begin
                eReq.address = 20'(back + int'(wr_addr));
                eReq.data = wr_data;
                eReq.we_n = 1'b0;
                eReq.den = 1'b1;
            end
        end
        check("sram_req", 64'(sram_req), 64'(eReq));
        check("disp_result", 64'(disp_result), 64'(eRes));
        check("wr_ready", 64'(wr_ready), 64'(rst_n && !mClearing && disp_req.oe_n));
        check("clr_busy", 64'(clr_busy), 64'(mClearing));
        check("front_sel", 64'(front_sel), 64'(mFront));
        check("disp_base", 64'(disp_base), 64'((mFront == 1) ? 307200 : 0));
        check("swap_pending", 64'(swap_pending), 64'(mPending));
        check("frame_count", 64'(frame_count), 64'(mFrames));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        sram_result.din = sram_result.din + 32'h0101_0101;
    endtask

    // Runs until clr_busy drops; counts busy cycles and fill writes landing in [base, base+PIX)
    task automatic runClear(input bit inject, input logic [31:0] color, input int base,
                            output int busyCnt, output int writes);
        bit finished;
        busyCnt = 0;
        writes = 0;
        finished = 0;
        wr_valid = 1'b1;
        wr_addr = 19'd7;
        wr_data = 32'h0000_0BAD;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!clr_busy) begin
                finished = 1;
                break;
            end
            busyCnt++;
            if (!sram_req.we_n && sram_req.data == color &&
                int'(sram_req.address) >= base && int'(sram_req.address) < base + PIX)
                writes++;
            @(posedge clk);
            #1;
            disp_req = (inject && n >= 20 && n < 30) ? readReq(20'h00010) : SRAM_IDLE;
            clr_start = (n == 5);
            clr_color = 32'hFFFF_FFFF;
        end
        check("clear_finished", 64'(finished), 64'd1);
        disp_req = SRAM_IDLE;
        clr_start = 1'b0;
        wr_valid = 1'b0;
    endtask

    initial begin
        int busyCnt;
        int writes;
        disp_req = SRAM_IDLE;
        sram_result = '{din: 32'h1234_5678, done: 1'b1};
        paint_done = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clr_start = 1'b0;
        clr_color = '0;
        swap_req = 1'b0;

        #2 rst_n = 1'b0;
        disp_req = readReq(20'h00100);
        repeat (3) tick();
        #1;
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_sram_oe_n", 64'(sram_req.oe_n), 64'd1);
        check("rst_disp_done", 64'(disp_result.done), 64'd0);
        rst_n = 1'b1;
        disp_req = SRAM_IDLE;
        tick();
        #1;
        check("idle_oe_n", 64'(sram_req.oe_n), 64'd1);
        check("idle_we_n", 64'(sram_req.we_n), 64'd1);
        check("idle_disp_base", 64'(disp_base), 64'd0);
        check("idle_front_sel", 64'(front_sel), 64'd0);
        check("idle_wr_ready", 64'(wr_ready), 64'd1);

        // Single renderer write into FB1, then the same cycle contended by a display read
        tick();
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 32'h0000_00A5;
        #1;
        check("wr_address", 64'(sram_req.address), 64'd307205);
        check("wr_we_n", 64'(sram_req.we_n), 64'd0);
        check("wr_den", 64'(sram_req.den), 64'd1);
        check("wr_data", 64'(sram_req.data), 64'h00A5);
        disp_req = readReq(20'h12345);
        #1;
        check("contend_wr_ready", 64'(wr_ready), 64'd0);
        check("contend_passthrough", 64'(sram_req), 64'(readReq(20'h12345)));
        tick();
        disp_req = SRAM_IDLE;
        wr_addr = 19'd64;
        #1;
        check("oob_wr_ready", 64'(wr_ready), 64'd1);
        check("oob_dropped", 64'(sram_req.we_n), 64'd1);
        wr_addr = 19'd63;
        #1;
        check("last_pixel_addr", 64'(sram_req.address), 64'd307263);
        tick();
        wr_valid = 1'b0;

        // Uninterrupted clear of the back buffer
        clr_color = 32'h0000_1234; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        runClear(1'b0, 32'h0000_1234, 307200, busyCnt, writes);
        check("clear_busy_cycles", 64'(busyCnt), 64'd64);
        check("clear_writes", 64'(writes), 64'd64);

        // Clear with ten display reads injected
        tick();
        clr_color = 32'h0000_4321; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        runClear(1'b1, 32'h0000_4321, 307200, busyCnt, writes);
        check("clear_stall_busy", 64'(busyCnt), 64'd74);
        check("clear_stall_writes", 64'(writes), 64'd64);

        // Requested swap performed at the next vblank edge
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        #1;
        check("swap_pending_set", 64'(swap_pending), 64'd1);
        repeat (3) tick();
        paint_done = 1'b1;
        tick();
        #1;
        check("swap_front_sel", 64'(front_sel), 64'd1);
        check("swap_disp_base", 64'(disp_base), 64'd307200);
        check("swap_pending_clr", 64'(swap_pending), 64'd0);
        check("swap_frame_count", 64'(frame_count), 64'd1);
        repeat (2) tick();
        paint_done = 1'b0;
        wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 32'h0000_0077;
        #1;
        check("post_swap_wr_addr", 64'(sram_req.address), 64'd5);
        tick();
        wr_valid = 1'b0;

        // Vblank during a clear defers the swap
        clr_color = 32'h0000_0055; clr_start = 1'b1;
        tick();
        clr_start = 1'b0; swap_req = 1'b1;
        tick();
        swap_req = 1'b0; paint_done = 1'b1;
        tick();
        #1;
        check("defer_pending", 64'(swap_pending), 64'd1);
        check("defer_front_sel", 64'(front_sel), 64'd1);
        check("defer_frame_count", 64'(frame_count), 64'd2);
        paint_done = 1'b0;
        runClear(1'b0, 32'h0000_0055, 0, busyCnt, writes);
        check("defer_clear_rest", 64'(busyCnt), 64'd62);
        check("defer_still_pending", 64'(swap_pending), 64'd1);
        tick();
        paint_done = 1'b1;
        tick();
        #1;
        check("deferred_swap_front", 64'(front_sel), 64'd0);
        check("deferred_swap_pending", 64'(swap_pending), 64'd0);
        check("deferred_frame_count", 64'(frame_count), 64'd3);
        paint_done = 1'b0;

        // swap_req coinciding with the edge swaps exactly once
        tick();
        paint_done = 1'b1; swap_req = 1'b1;
        tick();
        paint_done = 1'b0; swap_req = 1'b0;
        #1;
        check("coincide_front", 64'(front_sel), 64'd1);
        check("coincide_pending", 64'(swap_pending), 64'd0);
        check("coincide_frames", 64'(frame_count), 64'd4);
        repeat (2) tick();
        #1;
        check("no_second_swap", 64'(swap_pending), 64'd0);

        // Reset in the middle of a clear
        clr_color = 32'h0000_0099; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(clr_busy), 64'd0);
        check("midrst_sram_idle", 64'(sram_req), 64'(SRAM_IDLE));
        check("midrst_front", 64'(front_sel), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        #1;
        check("post_rst_no_write", 64'(sram_req.we_n), 64'd1);
        check("post_rst_busy", 64'(clr_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
Shares the single SRAM port between three users: the VGA display read path, a pixel writer (renderer), and a built-in back-buffer clear engine. It manages double buffering with two framebuffers in SRAM. It publishes the front-buffer base address to the display adapter and swaps front and back only at the start of vertical blank. It sits between the display adapter, the renderer and the SRAM controller.

Parameters:
FB0_BASE, 0, SRAM word address of framebuffer 0
FB1_BASE, 307200, SRAM word address of framebuffer 1 (640*480)
FB_PIXELS, 307200, pixels per buffer; the clear length and the write-offset limit
FRAME_CNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
disp_req  in  SramRequest_t  display adapter request; read when oe_n==0
disp_result  out  SramResult_t  result returned to the display adapter
disp_base  out  SramAddress_t  front-buffer base, fed to the display adapter baseAddress
paint_done  in  1  display paintDone; high during vertical blank
wr_valid  in  1  renderer write request
wr_addr  in  19  pixel offset within the back buffer
wr_data  in  32  pixel word
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
clr_start  in  1  pulse: fill the back buffer with clr_color
clr_color  in  32  fill value, latched on accepted clr_start
clr_busy  out  1  clear engine active
swap_req  in  1  pulse: request a front/back swap at the next vblank
swap_pending  out  1  swap requested, not yet performed
front_sel  out  1  0: FB0 is front, 1: FB1 is front
frame_count  out  FRAME_CNT_W  count of paint_done rising edges, wraps
sram_req  out  SramRequest_t  request to the SRAM controller
sram_result  in  SramResult_t  SRAM controller result, valid in the same cycle as the request

Behaviour:
- Reset (async, rst_n low):
  - front_sel=0, disp_base=FB0_BASE, swap_pending=0, clr_busy=0, frame_count=0, state=IDLE, paint_done_q=0.
  - sram_req idle: oe_n=1, we_n=1, den=0, address=0.
  - wr_ready=0 and disp_result.done=0 while rst_n is low.
- Bases: front_base = front_sel ? FB1_BASE : FB0_BASE; back_base is the other buffer. Both derive from registered front_sel.
- Per-cycle arbitration is combinational, fixed priority:
  - 1) display read (disp_req.oe_n==0): sram_req = disp_req unchanged. disp_result.din = sram_result.din; disp_result.done = sram_result.done.
  - 2) CLEAR state write.
  - 3) renderer write.
  - disp_result.done=0 in any cycle the display is not granted.
- Display is never stalled. Writes and clears use only cycles in which the display is idle (blanking periods).
- Write path: wr_ready = rst_n && state==IDLE && disp_req.oe_n.
  - On accept: sram_req.address = back_base + wr_addr, we_n=0, den=1, oe_n=1, data=wr_data.
  - Single-cycle write; no response to the writer.
  - wr_addr >= FB_PIXELS: accepted (wr_ready high), no SRAM cycle issued, write dropped.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start: latch clr_color, cnt=0.
  - In CLEAR, each cycle the display is idle: write clr_color to back_base+cnt, then cnt++. Display cycles stall cnt.
  - After writing cnt==FB_PIXELS-1 -> IDLE. clr_busy = (state==CLEAR).
  - clr_start in CLEAR is ignored.
- Swap:
  - swap_req sets swap_pending. paint_done_q is paint_done registered; a vblank edge is paint_done && !paint_done_q.
  - On an edge with (swap_pending || swap_req) and state==IDLE: toggle front_sel, clear swap_pending. disp_base follows on the next cycle.
  - Edge while in CLEAR: swap deferred to a later edge; swap_pending stays 1.
  - swap_req on the swap cycle itself is absorbed by that swap; no second swap.
  - frame_count increments on every edge, whether or not a swap occurs; wraps modulo 2^FRAME_CNT_W.
  - A write accepted in the swap cycle targets the old back_base.

Decomposition:
- DataType package additions:
  - FbSel_t.
  - FB_PIXELS, FB0_BASE, FB1_BASE constants shared with the display adapter.
  - ClearState_t enum {IDLE, CLEAR}.
- Reuse the existing SramRequest_t, SramResult_t and SramAddress_t.
- One natural sub-module: fb_clear_engine (counter, latched color, busy flag). The arbiter mux and swap logic stay in the top module.

Test Plan:
- Reset release, no traffic -> sram_req.oe_n=1, we_n=1; disp_base=0; front_sel=0; wr_ready=1.
- wr_valid with wr_addr=5, wr_data=0xA5, display idle, front_sel=0 -> sram_req.address=307205, we_n=0, den=1 in the same cycle. With disp_req.oe_n=0 in that cycle -> wr_ready=0 and sram_req equals disp_req.
- clr_start with color 0x1234 and the display idle throughout -> exactly 307200 writes, FB1 addresses 307200..614399, clr_busy high for 307200 cycles. Inject 10 display reads mid-clear -> clr_busy high for 307210 cycles.
- swap_req at frame line 100, then paint_done rises -> one cycle later front_sel=1, disp_base=307200, swap_pending=0, frame_count=1. Subsequent writes go to FB0.
- swap_req pending and clear in progress at the paint_done edge -> no swap, swap_pending stays 1, frame_count increments. Swap occurs at the next edge after the clear finishes.
- rst_n asserted mid-clear (cnt=1000) -> clr_busy=0, sram_req idle immediately, front_sel=0. No writes after rst_n is released until a new clr_start.
